bcd_tick_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with an integrated tick divider and a multiplexed digit-scan output. It replaces the separate divider-plus-derived-clock arrangement. Everything runs on the board clock, and the divider produces a one-cycle count enable rather than a new clock. It sits between the board clock/reset pins and the LED/7-segment display logic.

---
 rtl/bcd_tick_counter.sv | 192 +++++++++++++++++++
 tb/tb_bcd_tick_counter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit BCD up/down counter stepped by an internal tick divider, with a multiplexed digit-scan output.
// Latency: count/wrap update on the edge after the tick cycle; a load shows on the edge it is sampled; scan_bcd is combinational.
// Backpressure: none; en and up are only sampled in the tick cycle, and load always wins over a step.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   en        count enable, sampled in tick cycles only
//   up        direction (1 = increment, 0 = decrement), sampled in tick cycles only
//   load      synchronous load strobe, highest priority
//   load_val  BCD value to load, digit 0 in [3:0]; nibbles above 9 load as 9
//   count     registered BCD count
//   tick      registered one-cycle pulse every CLK_HZ/TICK_HZ cycles
//   wrap      registered one-cycle pulse on an all-9s <-> all-0s rollover
//   scan_an   one-hot active-high digit select, advances every SCAN_DIV cycles
//   scan_bcd  nibble of the digit selected by scan_an
//
// Optional feature: define BCD_TICK_COUNTER_SATURATE_EN to hold at all-9s / all-0s
// instead of wrapping; wrap then never asserts.
module bcd_tick_counter #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_DIV = 50_000,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [DIGITS-1:0]     scan_an,
  output logic [3:0]            scan_bcd
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_q,      div_d;
  logic                  tick_q,     tick_d;
  logic [4*DIGITS-1:0]   count_q,    count_d;
  logic                  wrap_q,     wrap_d;
  logic [SCAN_W-1:0]     scan_div_q, scan_div_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;

  // Combinational step result and rollover detection.
  logic [4*DIGITS-1:0]   step_val;
  logic                  all_nines;
  logic                  all_zeros;
  logic                  wrap_cond;

  // Clamp every nibble of a BCD word to the range 0..9.
  function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Tick divider: free-running, never gated by en or load.
  // tick_q is registered so that it is high exactly while div_q == DIV-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  // ---------------------------------------------------------------------------
  // Parallel BCD step: the carry/borrow is resolved across all digits in one
  // cycle, so a multi-digit rollover lands on a single edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    step_val  = count_q;
    all_nines = 1'b1;
    all_zeros = 1'b1;
    carry     = 1'b1;           // digit 0 always steps
    digit     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (digit != 4'd9) all_nines = 1'b0;
      if (digit != 4'd0) all_zeros = 1'b0;
      if (carry) begin
        if (up) begin
          if (digit >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    wrap_cond = up ? all_nines : all_zeros;
  end

  // ---------------------------------------------------------------------------
  // Count next state: load > (tick & en) > hold. A load in a tick cycle
  // consumes that tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_bcd(load_val);
    end else if (tick_q && en) begin
`ifdef BCD_TICK_COUNTER_SATURATE_EN
      // At the end of the range the step is dropped rather than wrapped.
      if (!wrap_cond) begin
        count_d = step_val;
      end
`else
      count_d = step_val;
      wrap_d  = wrap_cond;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan: index advances on the edge after the scan divider hits its
  // last value. With one digit the index is pinned at 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_div_d = (scan_div_q == SCAN_LAST) ? '0 : scan_div_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_div_q == SCAN_LAST) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    scan_an  = '0;
    scan_bcd = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        scan_an[i] = 1'b1;
        scan_bcd   = count_q[4*i +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_div_q <= '0;
      scan_idx_q <= '0;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_div_q <= scan_div_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter with DIV=10, SCAN_DIV=4, DIGITS=2.
// A table of load/step records drives the main counting checks against a
// decimal reference model; hand-written sequences cover tick timing after
// reset, load-in-tick-cycle, digit scanning and asynchronous reset.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tick;
  logic       wrap;
  logic [1:0] scan_an;
  logic [3:0] scan_bcd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // rising edges since the last reset release
  int model  = 0;   // reference count as a decimal 0..99

  always #5 clk = ~clk;

  bcd_tick_counter #(
    .CLK_HZ  (100),
    .TICK_HZ (10),
    .SCAN_DIV(4),
    .DIGITS  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tick    (tick),
    .wrap    (wrap),
    .scan_an (scan_an),
    .scan_bcd(scan_bcd)
  );

  typedef struct {
    string      name;
    bit         do_load;
    logic [7:0] lval;
    logic [7:0] load_exp;
    bit         v_en;
    bit         v_up;
    int         ticks;
    logic [7:0] fin;
    int         wraps;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int clamp_dec(input logic [7:0] b);
    int hi;
    int lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  // Advance until tick is seen (bounded). en/up are flipped on every
  // non-tick cycle to show they are ignored outside the tick cycle.
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (tick === 1'b1) begin
        seen = 1'b1;
      end else begin
        en = ~en;
        up = ~up;
        step();
      end
    end
    check($sformatf("%s tick_seen", name), 32'(seen), 32'd1);
    if (seen) check($sformatf("%s tick_phase", name), 32'(cyc % 10), 32'd9);
  endtask

  task automatic do_tick(input string name, input bit e, input bit u, inout int wraps);
    bit exp_wrap;
    wait_tick(name);
    en = e;
    up = u;
    exp_wrap = 1'b0;
    if (e) begin
      if (u) begin
        if (model == 99) begin
`ifndef BCD_TICK_COUNTER_SATURATE_EN
          model    = 0;
          exp_wrap = 1'b1;
`endif
        end else begin
          model++;
        end
      end else begin
        if (model == 0) begin
`ifndef BCD_TICK_COUNTER_SATURATE_EN
          model    = 99;
          exp_wrap = 1'b1;
`endif
        end else begin
          model--;
        end
      end
    end
    step();
    check($sformatf("%s count", name), 32'(count), 32'(to_bcd(model)));
    check($sformatf("%s wrap", name), 32'(wrap), 32'(exp_wrap));
    check($sformatf("%s tick_width", name), 32'(tick), 32'd0);
    if (wrap === 1'b1) wraps++;
    step();
    check($sformatf("%s wrap_pulse", name), 32'(wrap), 32'd0);
  endtask

  task automatic do_load(input string name, input logic [7:0] v, input logic [7:0] exp_v);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
    load_val = 8'h00;
    model    = clamp_dec(v);
    check($sformatf("%s load", name), 32'(count), 32'(exp_v));
    check($sformatf("%s load_wrap", name), 32'(wrap), 32'd0);
  endtask

  // Release reset between edges and check the first tick lands in the
  // tenth cycle after release (divider reaches 9 after nine edges).
  task automatic release_reset(input string name);
    int first;
    #2;
    rst   = 1'b0;
    cyc   = 0;
    model = 0;
    first = -1;
    for (int k = 1; k <= 15 && first < 0; k++) begin
      step();
      if (tick === 1'b1) first = k;
    end
    check($sformatf("%s first_tick_edge", name), 32'(first), 32'd9);
    check($sformatf("%s count_after_release", name), 32'(count), 32'h00);
  endtask

  initial begin
    int wraps;
    int last_tick;
    int guard;

    // Records: name, do_load, load_val, expected after load, en, up, ticks,
    // expected final count, expected number of wrap pulses.
    vecs[0] = '{"up10",     1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 10, 8'h10, 0};
`ifdef BCD_TICK_COUNTER_SATURATE_EN
    vecs[1] = '{"load98",   1'b1, 8'h98, 8'h98, 1'b1, 1'b1, 2,  8'h99, 0};
    vecs[2] = '{"down0",    1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1,  8'h00, 0};
    vecs[3] = '{"hold",     1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3,  8'h00, 0};
    vecs[4] = '{"clampAB",  1'b1, 8'hAB, 8'h99, 1'b1, 1'b1, 1,  8'h99, 0};
`else
    vecs[1] = '{"load98",   1'b1, 8'h98, 8'h98, 1'b1, 1'b1, 2,  8'h00, 1};
    vecs[2] = '{"down0",    1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1,  8'h99, 1};
    vecs[3] = '{"hold",     1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3,  8'h99, 0};
    vecs[4] = '{"clampAB",  1'b1, 8'hAB, 8'h99, 1'b1, 1'b1, 1,  8'h00, 1};
`endif
    vecs[5] = '{"borrow40", 1'b1, 8'h40, 8'h40, 1'b1, 1'b0, 1,  8'h39, 0};
    vecs[6] = '{"carry59",  1'b1, 8'h59, 8'h59, 1'b1, 1'b1, 1,  8'h60, 0};
    vecs[7] = '{"clampA5",  1'b1, 8'hA5, 8'h95, 1'b1, 1'b0, 2,  8'h93, 0};

    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    #3;
    check("rst count", 32'(count), 32'h00);
    check("rst tick", 32'(tick), 32'd0);
    check("rst wrap", 32'(wrap), 32'd0);
    check("rst scan_an", 32'(scan_an), 32'h1);
    check("rst scan_bcd", 32'(scan_bcd), 32'h0);
    step();
    step();
    check("rst held tick", 32'(tick), 32'd0);

    release_reset("por");

    // Table-driven counting.
    for (int v = 0; v < 8; v++) begin
      wraps = 0;
      if (vecs[v].do_load) do_load(vecs[v].name, vecs[v].lval, vecs[v].load_exp);
      for (int t = 0; t < vecs[v].ticks; t++) begin
        do_tick(vecs[v].name, vecs[v].v_en, vecs[v].v_up, wraps);
      end
      check($sformatf("%s final", vecs[v].name), 32'(count), 32'(vecs[v].fin));
      check($sformatf("%s wraps", vecs[v].name), 32'(wraps), 32'(vecs[v].wraps));
    end

    // Load coincident with a tick: load wins, nibble clamped, no step.
    wait_tick("ldtick");
    last_tick = cyc;
    load      = 1'b1;
    load_val  = 8'h4F;
    en        = 1'b1;
    up        = 1'b1;
    step();
    load      = 1'b0;
    load_val  = 8'h00;
    model     = 49;
    check("ldtick count", 32'(count), 32'h49);
    step();
    check("ldtick no_step", 32'(count), 32'h49);
    wait_tick("ldtick next");
    check("ldtick spacing", 32'(cyc - last_tick), 32'd10);
    check("ldtick hold_until_tick", 32'(count), 32'h49);
    en = 1'b0;
    step();

    // Digit scan with count = 37: index is (edges since release / 4) mod 2.
    en = 1'b0;
    do_load("scan", 8'h37, 8'h37);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("scan an c%0d", cyc), 32'(scan_an),
            32'((((cyc / 4) % 2) == 1) ? 2'b10 : 2'b01));
      check($sformatf("scan bcd c%0d", cyc), 32'(scan_bcd),
            32'((((cyc / 4) % 2) == 1) ? 4'h3 : 4'h7));
      step();
    end

    // Asynchronous reset mid-count with divider at 5.
    do_load("arst", 8'h42, 8'h42);
    guard = 0;
    while ((cyc % 10) != 5 && guard < 12) begin
      step();
      guard++;
    end
    check("arst divider_phase", 32'(cyc % 10), 32'd5);
    check("arst pre_count", 32'(count), 32'h42);
    #2;
    rst = 1'b1;
    #1;
    check("arst count", 32'(count), 32'h00);
    check("arst tick", 32'(tick), 32'd0);
    check("arst wrap", 32'(wrap), 32'd0);
    check("arst scan_an", 32'(scan_an), 32'h1);
    check("arst scan_bcd", 32'(scan_bcd), 32'h0);
    step();
    step();
    release_reset("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
